// File: rtl/sprite_pal_pkg.sv
// Shared types, constants and helpers for the sprite palette RAM.
// The init defaults are defined here so other palette logic can reuse them.
package sprite_pal_pkg;

   localparam int CH_BITS = 4;

   typedef struct packed {
      logic [CH_BITS-1:0] r;
      logic [CH_BITS-1:0] g;
      logic [CH_BITS-1:0] b;
   } rgb_t;

   // Magenta key colour marks index 0 of every bank.
   localparam rgb_t KEY_RGB = '{
      r: {CH_BITS{1'b1}},
      g: {CH_BITS{1'b0}},
      b: {CH_BITS{1'b1}}
   };

   typedef enum logic {
      INIT,
      RUN
   } state_t;

   function automatic int unsigned default_grey(
      input int unsigned i,
      input int unsigned idx_w,
      input int unsigned ch_w
   );
      if (ch_w >= idx_w)
         return i << (ch_w - idx_w);
      else
         return i >> (idx_w - ch_w);
   endfunction

endpackage

// File: rtl/sprite_palette_ram_ram.sv
// Simple dual-port synchronous RAM, read-first, no reset.
// Kept free of reset so synthesis maps it onto block RAM.
module pal_ram_1r1w #(
   parameter int DEPTH = 192,
   parameter int AW    = 8,
   parameter int DW    = 12
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/sprite_palette_ram.sv
// Multi-bank run-time writable sprite colour lookup with a 2-cycle read
// pipeline, transparency flag, dim mode and self-initialising defaults.
module sprite_palette_ram
   import sprite_pal_pkg::*;
#(
   parameter  int IDX_W   = 4,
   parameter  int NUM_PAL = 12,
   parameter  int CH_W    = 4,
   localparam int PAL_W   = $clog2(NUM_PAL)
) (
   input  logic              clk,
   input  logic              reset,
   output logic              busy,
   input  logic              pix_valid_in,
   input  logic [PAL_W-1:0]  pal_sel,
   input  logic [IDX_W-1:0]  index,
   output logic              pix_valid_out,
   output logic [CH_W-1:0]   red,
   output logic [CH_W-1:0]   green,
   output logic [CH_W-1:0]   blue,
   output logic              transparent,
   input  logic              dim_en,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [PAL_W-1:0]  wr_pal,
   input  logic [IDX_W-1:0]  wr_index,
   input  logic [3*CH_W-1:0] wr_rgb
);

   localparam int DEPTH = NUM_PAL << IDX_W;
   localparam int AW    = PAL_W + IDX_W;
   localparam int DW    = 3 * CH_W;

   state_t          state;
   logic [AW-1:0]   cnt;

   logic            s1_valid;
   logic            s1_oor;
   logic            s1_key;
   logic            s1_dim;

   logic [IDX_W-1:0] init_idx;
   logic [CH_W-1:0]  grey;
   logic [DW-1:0]    init_word;

   logic            wr_ok;
   logic            rd_oor;
   logic            ram_we;
   logic [AW-1:0]   ram_waddr;
   logic [DW-1:0]   ram_wdata;
   logic [AW-1:0]   ram_raddr;
   logic [DW-1:0]   rd_word;

   logic [CH_W-1:0] rd_r;
   logic [CH_W-1:0] rd_g;
   logic [CH_W-1:0] rd_b;

   assign init_idx = cnt[IDX_W-1:0];
   assign grey     = CH_W'(default_grey(32'(init_idx), IDX_W, CH_W));

   always_comb begin
      init_word = {grey, grey, grey};
      if (init_idx == '0)
         init_word = {{CH_W{1'b1}}, {CH_W{1'b0}}, {CH_W{1'b1}}};
   end

   // Writes to a bank that does not exist complete but are dropped.
   assign wr_ok  = wr_valid && wr_ready && (32'(wr_pal) < NUM_PAL);
   assign rd_oor = 32'(pal_sel) >= NUM_PAL;

   always_comb begin
      ram_we    = wr_ok;
      ram_waddr = {wr_pal, wr_index};
      ram_wdata = wr_rgb;
      if (state == INIT) begin
         ram_we    = 1'b1;
         ram_waddr = cnt;
         ram_wdata = init_word;
      end
   end

   // Out-of-range banks read a harmless address; the result is masked.
   assign ram_raddr = rd_oor ? '0 : {pal_sel, index};

   pal_ram_1r1w #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .DW    (DW)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .raddr (ram_raddr),
      .rdata (rd_word)
   );

   assign rd_r = rd_word[3*CH_W-1 -: CH_W];
   assign rd_g = rd_word[2*CH_W-1 -: CH_W];
   assign rd_b = rd_word[CH_W-1 -: CH_W];

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= INIT;
         cnt           <= '0;
         busy          <= 1'b1;
         wr_ready      <= 1'b0;
         s1_valid      <= 1'b0;
         s1_oor        <= 1'b0;
         s1_key        <= 1'b0;
         s1_dim        <= 1'b0;
         pix_valid_out <= 1'b0;
         red           <= '0;
         green         <= '0;
         blue          <= '0;
         transparent   <= 1'b0;
      end else begin
         unique case (state)
            INIT: begin
               if (cnt == AW'(DEPTH - 1)) begin
                  state    <= RUN;
                  busy     <= 1'b0;
                  wr_ready <= 1'b1;
               end else begin
                  cnt <= cnt + AW'(1);
               end
            end
            RUN: begin
               busy     <= 1'b0;
               wr_ready <= 1'b1;
            end
         endcase

         s1_valid <= pix_valid_in && (state == RUN);
         s1_oor   <= rd_oor;
         s1_key   <= (index == '0);
         s1_dim   <= dim_en;

         pix_valid_out <= s1_valid;
         if (s1_valid) begin
            if (s1_oor) begin
               red         <= '0;
               green       <= '0;
               blue        <= '0;
               transparent <= 1'b1;
            end else begin
               red         <= s1_dim ? (rd_r >> 1) : rd_r;
               green       <= s1_dim ? (rd_g >> 1) : rd_g;
               blue        <= s1_dim ? (rd_b >> 1) : rd_b;
               transparent <= s1_key;
            end
         end
      end
   end

endmodule

// File: tb/tb_sprite_palette_ram.sv
// Directed bench for sprite_palette_ram: init sequence, lookups, writes,
// read-first collisions, dim, out-of-range banks and mid-run reset.
module tb_sprite_palette_ram;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        busy;
   logic        pix_valid_in = 1'b0;
   logic [3:0]  pal_sel = '0;
   logic [3:0]  index = '0;
   logic        pix_valid_out;
   logic [3:0]  red;
   logic [3:0]  green;
   logic [3:0]  blue;
   logic        transparent;
   logic        dim_en = 1'b0;
   logic        wr_valid = 1'b0;
   logic        wr_ready;
   logic [3:0]  wr_pal = '0;
   logic [3:0]  wr_index = '0;
   logic [11:0] wr_rgb = '0;

   int n_cmp = 0;
   int n_bad = 0;

   logic [11:0] shadow [192];

   typedef struct {
      logic [3:0]  pal;
      logic [3:0]  idx;
      logic        dim;
      logic [11:0] rgb;
      logic        t;
   } vec_t;

   vec_t vecs [10];

   sprite_palette_ram dut (
      .clk           (clk),
      .reset         (reset),
      .busy          (busy),
      .pix_valid_in  (pix_valid_in),
      .pal_sel       (pal_sel),
      .index         (index),
      .pix_valid_out (pix_valid_out),
      .red           (red),
      .green         (green),
      .blue          (blue),
      .transparent   (transparent),
      .dim_en        (dim_en),
      .wr_valid      (wr_valid),
      .wr_ready      (wr_ready),
      .wr_pal        (wr_pal),
      .wr_index      (wr_index),
      .wr_rgb        (wr_rgb)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [13:0] act,
                        input logic [13:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [13:0] outw();
      return {pix_valid_out, transparent, red, green, blue};
   endfunction

   task automatic defaults;
      for (int a = 0; a < 192; a++) begin
         logic [3:0] i;
         i = 4'(a % 16);
         shadow[a] = (i == 0) ? 12'hF0F : {i, i, i};
      end
   endtask

   function automatic logic [13:0] model(input logic [3:0] pal,
                                         input logic [3:0] idx,
                                         input logic dim);
      logic [11:0] w;
      if (pal >= 12)
         return {2'b11, 12'h000};
      w = shadow[{pal, idx}];
      if (dim)
         w = {1'b0, w[11:9], 1'b0, w[7:5], 1'b0, w[3:1]};
      return {1'b1, idx == 0, w};
   endfunction

   task automatic lookup(input logic [3:0] p, input logic [3:0] i,
                         input logic d);
      pix_valid_in = 1'b1;
      pal_sel      = p;
      index        = i;
      dim_en       = d;
   endtask

   task automatic idle;
      pix_valid_in = 1'b0;
      dim_en       = 1'b0;
   endtask

   task automatic single(input string name, input logic [3:0] p,
                         input logic [3:0] i, input logic d,
                         input logic [11:0] rgb, input logic t);
      lookup(p, i, d);
      tick;
      idle;
      tick;
      check(name, outw(), {1'b1, t, rgb});
   endtask

   task automatic write(input logic [3:0] p, input logic [3:0] i,
                        input logic [11:0] rgb);
      wr_valid = 1'b1;
      wr_pal   = p;
      wr_index = i;
      wr_rgb   = rgb;
      check("wr_ready", 14'(wr_ready), 14'(1));
      tick;
      wr_valid = 1'b0;
      if (p < 12)
         shadow[{p, i}] = rgb;
   endtask

   task automatic readback(input string name);
      for (int k = 0; k <= 192; k++) begin
         if (k < 192)
            lookup(4'(k / 16), 4'(k % 16), 1'b0);
         else
            idle;
         tick;
         if (k >= 1)
            check(name, outw(),
                  model(4'((k - 1) / 16), 4'((k - 1) % 16), 1'b0));
      end
   endtask

   initial begin
      int n;
      int bad_init;

      vecs[0] = '{4'd3,  4'd0,  1'b0, 12'hF0F, 1'b1};
      vecs[1] = '{4'd3,  4'd9,  1'b0, 12'h999, 1'b0};
      vecs[2] = '{4'd5,  4'd7,  1'b0, 12'h3A6, 1'b0};
      vecs[3] = '{4'd5,  4'd7,  1'b1, 12'h153, 1'b0};
      vecs[4] = '{4'd13, 4'd4,  1'b0, 12'h000, 1'b1};
      vecs[5] = '{4'd0,  4'd15, 1'b1, 12'h777, 1'b0};
      vecs[6] = '{4'd11, 4'd0,  1'b1, 12'h707, 1'b1};
      vecs[7] = '{4'd15, 4'd0,  1'b0, 12'h000, 1'b1};
      vecs[8] = '{4'd11, 4'd1,  1'b0, 12'h111, 1'b0};
      vecs[9] = '{4'd5,  4'd6,  1'b0, 12'h666, 1'b0};
      defaults;

      tick;
      check("rst_out", outw(), 14'h0);
      check("rst_ctl", {12'h0, busy, wr_ready}, 14'b10);

      reset = 1'b0;
      lookup(4'd3, 4'd0, 1'b0);
      n = 0;
      bad_init = 0;
      while (busy === 1'b1 && n < 400) begin
         if (pix_valid_out !== 1'b0 || wr_ready !== 1'b0)
            bad_init++;
         n++;
         tick;
      end
      idle;
      check("init_len", 14'(n), 14'd192);
      check("init_quiet", 14'(bad_init), 14'd0);
      check("run_ctl", {12'h0, busy, wr_ready}, 14'b01);
      tick;
      check("init_drop", 14'(pix_valid_out), 14'd0);

      single("key", 4'd3, 4'd0, 1'b0, 12'hF0F, 1'b1);
      single("grey9", 4'd3, 4'd9, 1'b0, 12'h999, 1'b0);

      lookup(4'd5, 4'd7, 1'b0);
      wr_valid = 1'b1;
      wr_pal   = 4'd5;
      wr_index = 4'd7;
      wr_rgb   = 12'h3A6;
      tick;
      wr_valid = 1'b0;
      shadow[{4'd5, 4'd7}] = 12'h3A6;
      tick;
      idle;
      check("rd_first", outw(), {2'b10, 12'h777});
      tick;
      check("rd_new", outw(), {2'b10, 12'h3A6});
      tick;
      check("hold", outw(), {2'b00, 12'h3A6});

      for (int i = 0; i <= 10; i++) begin
         if (i < 10)
            lookup(vecs[i].pal, vecs[i].idx, vecs[i].dim);
         else
            idle;
         tick;
         if (i >= 1)
            check("stream", outw(),
                  {1'b1, vecs[i-1].t, vecs[i-1].rgb});
      end

      write(4'd14, 4'd7, 12'hFFF);
      write(4'd12, 4'd0, 12'hFFF);
      readback("readback_oor");

      write(4'd2, 4'd3, 12'h123);
      write(4'd11, 4'd15, 12'hABC);
      single("wr_2_3", 4'd2, 4'd3, 1'b0, 12'h123, 1'b0);
      lookup(4'd2, 4'd3, 1'b0);
      tick;
      lookup(4'd11, 4'd15, 1'b0);
      reset = 1'b1;
      tick;
      reset = 1'b0;
      idle;
      check("rst_flush", {12'h0, pix_valid_out, busy}, 14'b01);
      tick;
      check("rst_flush2", 14'(pix_valid_out), 14'd0);
      n = 0;
      while (busy === 1'b1 && n < 400) begin
         n++;
         tick;
      end
      check("init2_done", {12'h0, busy, wr_ready}, 14'b01);
      defaults;
      readback("readback_reinit");

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sprite_palette_ram.md
Name: sprite_palette_ram

Overview:
Run-time writable, multi-bank colour lookup for sprite rendering. It replaces the fixed per-piece combinational palettes with one RAM holding NUM_PAL banks of 2^IDX_W RGB entries, so piece colour schemes can be changed without resynthesis. It sits between the sprite ROM index fetch and the VGA colour mux. It provides a 2-cycle registered read pipeline, a transparency flag, a dim mode for highlighting, and a self-initialising reset sequence.

Parameters:
IDX_W, 4, colour index width; each bank holds 2^IDX_W entries.
NUM_PAL, 12, number of palette banks (6 piece types x 2 sides).
CH_W, 4, bits per colour channel.
PAL_W, $clog2(NUM_PAL), bank select width (derived; not overridden).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
busy  out  1  high while the init sequencer runs
pix_valid_in  in  1  lookup request valid
pal_sel  in  PAL_W  bank for the lookup
index  in  IDX_W  colour index for the lookup
pix_valid_out  out  1  output colour valid
red, green, blue  out  CH_W each  looked-up colour
transparent  out  1  pixel must not be drawn
dim_en  in  1  halve output colour; sampled with the pixel
wr_valid  in  1  palette write request
wr_ready  out  1  write accepted when wr_valid && wr_ready
wr_pal  in  PAL_W  bank to write
wr_index  in  IDX_W  entry to write
wr_rgb  in  3*CH_W  {r,g,b} to store

Behaviour:
- Storage: NUM_PAL*2^IDX_W words of 3*CH_W bits. Linear address = pal*2^IDX_W + idx. Synchronous read; one read port and one write port.
- FSM states: INIT and RUN.
  - reset=1 puts the FSM in INIT with init counter = 0 and clears both pipeline stages.
  - INIT writes one entry per cycle at the counter address, then increments the counter.
  - After the last address (NUM_PAL*2^IDX_W-1) is written, the FSM moves to RUN on the next cycle. Default config takes 192 cycles.
- Init defaults:
  - Entry index 0 of every bank = key colour {max,0,max}.
  - Entry i>0 = grey g on all channels. g = i<<(CH_W-IDX_W) if CH_W>=IDX_W, else i>>(IDX_W-CH_W).
- busy = (state==INIT). wr_ready = (state==RUN).
- During INIT:
  - pix_valid_in is ignored.
  - pix_valid_out = 0.
  - External writes are not accepted.
- Reset values: pix_valid_out=0, red/green/blue=0, transparent=0, busy=1 from the cycle after reset, wr_ready=0.
- Read pipeline (RUN only):
  - Stage 1, cycle N: register valid, out-of-range flag (pal_sel>=NUM_PAL), index==0 flag and dim_en; issue the RAM read.
  - Stage 2, cycle N+1: form the outputs. Outputs are valid at the edge ending cycle N+1, so latency = 2 clocks.
  - Full throughput: one lookup per cycle, no backpressure.
- Output rules:
  - Out of range: rgb=0 and transparent=1.
  - Otherwise transparent = (index==0); rgb = stored value, each channel >>1 when the captured dim_en=1.
  - The transparency flag is independent of stored contents and of dim.
  - When the output is not valid, rgb and transparent hold their last value; only pix_valid_out drops.
- Writes:
  - Take effect at the clock edge when wr_valid && wr_ready.
  - wr_pal >= NUM_PAL: the handshake completes and the data is discarded.
- Same-address read and write in the same cycle: read-first, so the lookup returns the old value and the new value is visible to lookups issued from the next cycle on.
- Reset asserted mid-operation (either state):
  - In-flight pixels are dropped.
  - The FSM restarts INIT from address 0, overwriting all user-written entries.

Decomposition:
- Package sprite_pal_pkg holds:
  - the rgb_t struct {r,g,b} parametrised by CH_W;
  - the key-colour constant;
  - the state enum {INIT, RUN};
  - the default-grey function.
- One sub-module: pal_ram_1r1w, a simple dual-port synchronous RAM with read-first semantics and no reset, so it infers block RAM. The FSM, default generation, pipeline and dim logic stay in the top.

Test Plan:
- Reset 1 cycle, then release -> busy=1 for exactly 192 cycles, wr_ready=0 throughout, then busy=0 and wr_ready=1. Pixels driven during INIT give pix_valid_out=0.
- After init, read pal 3 idx 0 -> 2 clocks later valid, rgb=F,0,F, transparent=1. Read pal 3 idx 9 -> rgb=9,9,9, transparent=0.
- Write pal 5 idx 7 = 12'h3A6, then read it back-to-back -> 3,A,6. Same-cycle read of the same address during the write -> old 7,7,7; read on the following cycle -> 3,A,6.
- Lookup with dim_en=1 on pal 5 idx 7 (3,A,6) -> 1,5,3. Stream 8 consecutive lookups -> 8 consecutive valid outputs in order with no bubbles.
- pal_sel=13 (out of range) -> rgb=0, transparent=1. Write with wr_pal=14 -> accepted, no bank changes (full readback unchanged).
- Write entries, assert reset for 1 cycle while 2 lookups are in flight -> pix_valid_out=0 next cycle, busy=1, and after 192 cycles the written entries read back as defaults.
